instr_fetch: RTL and testbench

Instruction fetch stage for the MIPS32 core. It holds the program counter and fetches 32-bit words from instruction memory over a request/acknowledge handshake. It presents one instruction at a time, together with its decoded fields (opcode, funct, shamt, register indices, immediate, jump target), directly to the control unit and register file. It accepts PC redirects from branch, jal and jr resolution.

---
 rtl/instr_fetch_pkg.sv | 26 ++
 rtl/instr_fetch_if.sv | 9 +
 rtl/instr_fetch_field_split.sv | 23 ++
 rtl/instr_fetch.sv | 103 ++++++++++
 tb/tb_instr_fetch.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: shared fetch-stage types, MIPS32 field positions and PC constants
package ifetch_pkg;
    typedef enum logic [1:0] {IDLE, REQ, HOLD, FLUSH} state_t;
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int RS_MSB = 25;
    localparam int RS_LSB = 21;
    localparam int RT_MSB = 20;
    localparam int RT_LSB = 16;
    localparam int RD_MSB = 15;
    localparam int RD_LSB = 11;
    localparam int SHAMT_MSB = 10;
    localparam int SHAMT_LSB = 6;
    localparam int FUNCT_MSB = 5;
    localparam int FUNCT_LSB = 0;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;
    localparam int JTARGET_MSB = 25;
    localparam int JTARGET_LSB = 0;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_STEP = 32'd4;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & ~32'h3;
    endfunction
endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: instruction memory request/acknowledge bus
interface instr_fetch_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;
    modport master(output req, addr, input ack, rdata);
    modport slave(input req, addr, output ack, rdata);
endinterface

// File: rtl/instr_fetch_field_split.sv
// instr_field_split: combinational MIPS32 instruction field decode, reusable by later stages
module instr_field_split
    import ifetch_pkg::*;
(
    input  logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [15:0] imm,
    output logic [25:0] jtarget
);
    assign opcode  = instr[OPCODE_MSB:OPCODE_LSB];
    assign rs      = instr[RS_MSB:RS_LSB];
    assign rt      = instr[RT_MSB:RT_LSB];
    assign rd      = instr[RD_MSB:RD_LSB];
    assign shamt   = instr[SHAMT_MSB:SHAMT_LSB];
    assign funct   = instr[FUNCT_MSB:FUNCT_LSB];
    assign imm     = instr[IMM_MSB:IMM_LSB];
    assign jtarget = instr[JTARGET_MSB:JTARGET_LSB];
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: MIPS32 fetch stage; optional IFETCH_ALIGN_CHECK_EN flags misaligned redirects
module instr_fetch
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst_n,
    instr_fetch_if.master      imem,
    input  logic               stall,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    output logic               instr_valid,
    output logic [31:0]        instr,
    output logic [31:0]        pc,
    output logic [31:0]        pc_plus4,
    output logic [5:0]         opcode,
    output logic [4:0]         rs,
    output logic [4:0]         rt,
    output logic [4:0]         rd,
    output logic [4:0]         shamt,
    output logic [5:0]         funct,
    output logic [15:0]        imm,
    output logic [25:0]        jtarget,
    output logic               misalign_err
);
    state_t      state, state_nxt;
    logic [31:0] fetch_pc, fetch_pc_nxt, req_addr;
    logic        take;

    // req_addr always tracks the address the memory is working on, so it drives the bus in REQ and FLUSH alike
    assign imem.addr    = req_addr;
    assign pc_plus4     = pc + PC_STEP;
    assign fetch_pc_nxt = redirect ? word_align(redirect_pc) : take ? req_addr + PC_STEP : fetch_pc;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // next state and handshake; an acked word is kept only when no redirect arrives with it
    always_comb begin
        state_nxt = state;
        imem.req  = 1'b0;
        take      = 1'b0;
        case (state)
            IDLE:  state_nxt = REQ;
            REQ: begin
                imem.req  = 1'b1;
                take      = imem.ack && !redirect;
                state_nxt = imem.ack ? (redirect ? REQ : HOLD) : (redirect ? FLUSH : REQ);
            end
            HOLD:  state_nxt = (redirect || !stall) ? REQ : HOLD;
            FLUSH: begin
                imem.req  = 1'b1;
                state_nxt = imem.ack ? REQ : FLUSH;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // fetch address, outstanding address and presented instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_VECTOR;
            req_addr    <= RESET_VECTOR;
            pc          <= RESET_VECTOR;
            instr       <= NOP_INSTR;
            instr_valid <= 1'b0;
        end else begin
            fetch_pc    <= fetch_pc_nxt;
            instr_valid <= state_nxt == HOLD;
            if (state_nxt == REQ) req_addr <= fetch_pc_nxt;
            if (take) begin
                pc    <= req_addr;
                instr <= imem.rdata;
            end
        end
    end

`ifdef IFETCH_ALIGN_CHECK_EN
    // one-cycle flag for a redirect target that was not word aligned
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) misalign_err <= 1'b0;
        else        misalign_err <= redirect && (redirect_pc[1:0] != 2'b00);
    end
`else
    assign misalign_err = 1'b0;
`endif

    instr_field_split u_split (
        .instr   (instr),
        .opcode  (opcode),
        .rs      (rs),
        .rt      (rt),
        .rd      (rd),
        .shamt   (shamt),
        .funct   (funct),
        .imm     (imm),
        .jtarget (jtarget)
    );
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed stimulus with a transaction-level fetch model checked every cycle
module tb_instr_fetch;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        instr_valid, misalign_err;
    logic [31:0] instr, pc, pc_plus4;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [25:0] jtarget;
    int checks = 0;
    int errors = 0;
    int wait_cycles = 0;
    int mem_cnt = 0;

`ifdef IFETCH_ALIGN_CHECK_EN
    localparam logic EXP_MIS = 1'b1;
`else
    localparam logic EXP_MIS = 1'b0;
`endif

    instr_fetch_if imem();

    instr_fetch dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem         (imem),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .opcode       (opcode),
        .rs           (rs),
        .rt           (rt),
        .rd           (rd),
        .shamt        (shamt),
        .funct        (funct),
        .imm          (imm),
        .jtarget      (jtarget),
        .misalign_err (misalign_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a == 32'h0 ? 32'h8C22_0004 : a ^ 32'h2108_0000;
    endfunction

    // memory: acks after wait_cycles request cycles, data is a fixed function of address
    initial begin
        imem.ack = 1'b0;
        imem.rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (!imem.req) begin
                imem.ack = 1'b0;
                mem_cnt = 0;
            end else begin
                if (imem.ack) mem_cnt = 0;
                imem.ack = mem_cnt >= wait_cycles;
                mem_cnt++;
            end
            imem.rdata = mem_word(imem.addr);
        end
    end

    // model: started, outstanding request (busy/addr/kill), next address, presented instruction
    logic        m_started = 1'b0, m_busy = 1'b0, m_kill = 1'b0, m_have = 1'b0, m_mis = 1'b0;
    logic [31:0] m_addr = 32'h0, m_nxt = 32'h0, m_pc = 32'h0, m_instr = 32'h0;

    task automatic model_step();
        logic [31:0] nxt2;
        nxt2 = redirect ? (redirect_pc & ~32'h3) : m_nxt;
        m_mis = EXP_MIS && redirect && redirect_pc[1:0] != 2'b00;
        if (!m_started) begin
            m_started = 1'b1;
            m_busy = 1'b1;
            m_addr = nxt2;
            m_nxt = nxt2;
        end else if (m_busy) begin
            if (imem.ack) begin
                if (m_kill || redirect) begin
                    m_kill = 1'b0;
                    m_addr = nxt2;
                    m_nxt = nxt2;
                end else begin
                    m_busy = 1'b0;
                    m_have = 1'b1;
                    m_pc = m_addr;
                    m_instr = mem_word(m_addr);
                    m_nxt = m_addr + 32'd4;
                end
            end else begin
                m_nxt = nxt2;
                if (redirect) m_kill = 1'b1;
            end
        end else if (m_have && (redirect || !stall)) begin
            m_have = 1'b0;
            m_busy = 1'b1;
            m_nxt = nxt2;
            m_addr = nxt2;
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            m_started = 1'b0; m_busy = 1'b0; m_kill = 1'b0; m_have = 1'b0; m_mis = 1'b0;
            m_addr = 32'h0; m_nxt = 32'h0; m_pc = 32'h0; m_instr = 32'h0;
        end else model_step();
        #1;
        if (rst_n) begin
            chk("m_req", imem.req, m_busy);
            if (m_busy) chk("m_addr", imem.addr, m_addr);
            chk("m_valid", instr_valid, m_have);
            chk("m_misalign", misalign_err, m_mis);
            if (m_have) begin
                chk("m_pc", pc, m_pc);
                chk("m_pc_plus4", pc_plus4, m_pc + 32'd4);
                chk("m_instr", instr, m_instr);
                chk("m_opcode", opcode, m_instr[31:26]);
                chk("m_rs", rs, m_instr[25:21]);
                chk("m_rt", rt, m_instr[20:16]);
                chk("m_rd", rd, m_instr[15:11]);
                chk("m_shamt", shamt, m_instr[10:6]);
                chk("m_funct", funct, m_instr[5:0]);
                chk("m_imm", imm, m_instr[15:0]);
                chk("m_jtarget", jtarget, m_instr[25:0]);
            end
        end
    end

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!instr_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("wait_valid", instr_valid, 1'b1);
    endtask

    task automatic do_redirect(input logic [31:0] target);
        redirect = 1'b1;
        redirect_pc = target;
        @(negedge clk);
        redirect = 1'b0;
    endtask

    initial begin
        logic [15:0] pat;
        pat = 16'b1011_0010_1110_0101;
        stall = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_req", imem.req, 1'b0);
        chk("rst_valid", instr_valid, 1'b0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_opcode", opcode, 6'h0);
        chk("rst_misalign", misalign_err, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_req", imem.req, 1'b1);
        chk("first_addr", imem.addr, 32'h0);
        @(negedge clk);
        chk("lw_valid", instr_valid, 1'b1);
        chk("lw_opcode", opcode, 6'b100011);
        chk("lw_rs", rs, 5'd1);
        chk("lw_rt", rt, 5'd2);
        chk("lw_imm", imm, 16'd4);
        chk("lw_pc", pc, 32'h0);
        chk("lw_pc_plus4", pc_plus4, 32'h4);
        repeat (5) begin
            @(negedge clk);
            chk("stall_req", imem.req, 1'b0);
            chk("stall_instr", instr, 32'h8C22_0004);
            chk("stall_pc", pc, 32'h0);
        end
        stall = 1'b0;
        @(negedge clk);
        chk("next_req", imem.req, 1'b1);
        chk("next_addr", imem.addr, 32'h4);
        stall = 1'b1;
        @(negedge clk);
        chk("second_pc", pc, 32'h4);
        chk("second_instr", instr, 32'h2108_0004);
        wait_cycles = 3;
        do_redirect(32'h40);
        chk("hold_redir_valid", instr_valid, 1'b0);
        chk("hold_redir_addr", imem.addr, 32'h40);
        do_redirect(32'h100);
        chk("flush_addr0", imem.addr, 32'h40);
        @(negedge clk);
        chk("flush_addr1", imem.addr, 32'h40);
        @(negedge clk);
        chk("flush_addr2", imem.addr, 32'h40);
        chk("flush_ack", imem.ack, 1'b1);
        @(negedge clk);
        chk("after_flush_addr", imem.addr, 32'h100);
        chk("after_flush_valid", instr_valid, 1'b0);
        wait_cycles = 0;
        wait_valid(20);
        chk("redir_pc", pc, 32'h100);
        stall = 1'b0;
        @(negedge clk);
        do_redirect(32'h200);
        stall = 1'b1;
        chk("req_redir_addr", imem.addr, 32'h200);
        chk("req_redir_valid", instr_valid, 1'b0);
        wait_valid(20);
        chk("req_redir_pc", pc, 32'h200);
        do_redirect(32'hFFFF_FFFC);
        wait_valid(20);
        chk("wrap_pc", pc, 32'hFFFF_FFFC);
        chk("wrap_pc_plus4", pc_plus4, 32'h0);
        stall = 1'b0;
        @(negedge clk);
        chk("wrap_req", imem.req, 1'b1);
        chk("wrap_addr", imem.addr, 32'h0);
        stall = 1'b1;
        wait_valid(20);
        do_redirect(32'h42);
        chk("mis_pulse", misalign_err, EXP_MIS);
        chk("mis_addr", imem.addr, 32'h40);
        @(negedge clk);
        chk("mis_clear", misalign_err, 1'b0);
        wait_cycles = 1;
        for (int i = 0; i < 16; i++) begin
            stall = pat[i];
            @(negedge clk);
        end
        wait_cycles = 5;
        stall = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_req", imem.req, 1'b0);
        chk("midrst_valid", instr_valid, 1'b0);
        chk("midrst_pc", pc, 32'h0);
        @(negedge clk);
        wait_cycles = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
